s_feeder: RTL

S_FEEDER -- requirements
Module: s_feeder

---
 rtl/sw_pkg.sv | 22 ++
 rtl/s_chunk_packer.sv | 37 +++
 rtl/s_feeder.sv | 130 +++++++++++++
 3 files changed

// File: rtl/sw_pkg.sv
// Shared constants and types for the base feeder.
// Holds chunk geometry, base codes and read FSM states.
package sw_pkg;

    localparam int PE_ARRAY_SIZE     = 4;
    localparam int PE_ARRAY_SIZE_LOG = 2;

    typedef enum logic [1:0] {
        BASE_A = 2'd0,
        BASE_C = 2'd1,
        BASE_G = 2'd2,
        BASE_T = 2'd3
    } base_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_EMIT = 2'd2,
        ST_END  = 2'd3
    } rd_state_t;

endpackage

// File: rtl/s_chunk_packer.sv
// One chunk buffer: packs bases in arrival order, then seals
// with a count and a last flag until it is freed.
module s_chunk_packer
    import sw_pkg::*;
#(
    parameter int N  = PE_ARRAY_SIZE,
    parameter int LG = PE_ARRAY_SIZE_LOG
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [1:0]    base,
    input  logic          last_in,
    input  logic          free,
    output logic [2*N-1:0] data,
    output logic [LG:0]   cnt,
    output logic          sealed,
    output logic          last
);

    always_ff @(posedge clk) begin
        if (rst || free) begin
            data   <= '0;
            cnt    <= '0;
            sealed <= 1'b0;
            last   <= 1'b0;
        end else if (push && !sealed) begin
            data[{cnt[LG-1:0], 1'b0} +: 2] <= base;
            cnt <= cnt + 1'b1;
            if (cnt == (LG+1)'(N-1) || last_in) begin
                sealed <= 1'b1;
                last   <= last_in;
            end
        end
    end

endmodule

// File: rtl/s_feeder.sv
// Ping-pong base feeder: packs host bases into chunks and hands
// one chunk per request to the calculator, ending with o_done.
module s_feeder #(
    parameter int PE_ARRAY_SIZE     = sw_pkg::PE_ARRAY_SIZE,
    parameter int PE_ARRAY_SIZE_LOG = sw_pkg::PE_ARRAY_SIZE_LOG
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_clear,
    input  logic [1:0]                   i_base,
    input  logic                         i_base_valid,
    input  logic                         i_base_last,
    output logic                         o_base_ready,
    input  logic                         i_request_s,
    output logic [2*PE_ARRAY_SIZE-1:0]   o_s,
    output logic [PE_ARRAY_SIZE_LOG:0]   o_s_valid,
    output logic                         o_s_strobe,
    output logic                         o_done
);
    import sw_pkg::*;

    localparam int N  = PE_ARRAY_SIZE;
    localparam int LG = PE_ARRAY_SIZE_LOG;

    rd_state_t      state;
    logic           clr;
    logic           wr_sel;
    logic           rd_sel;
    logic           last_seen;
    logic           eos_pend;
    logic           marker;
    logic           done_q;
    logic           accept;
    logic           seal_now;
    logic           avail;
    logic           emit_chunk;
    logic           fin_now;
    logic [2*N-1:0] data [2];
    logic [LG:0]    cnt [2];
    logic [1:0]     sealed;
    logic [1:0]     last;
    logic [1:0]     push;
    logic [1:0]     free;

    assign clr        = rst | i_clear;
    assign accept     = i_base_valid & o_base_ready;
    assign seal_now   = accept & ((cnt[wr_sel] == (LG+1)'(N-1)) | i_base_last);
    // With no sealed buffer the read pointer sits on the write buffer,
    // so a seal happening this cycle is visible to the request.
    assign avail      = sealed[rd_sel] | seal_now;
    assign emit_chunk = (state == ST_EMIT) & ~marker;
    assign fin_now    = marker | (last[rd_sel] & (cnt[rd_sel] != (LG+1)'(N)));

    for (genvar g = 0; g < 2; g++) begin : g_buf
        assign push[g] = accept & (wr_sel == 1'(g));
        assign free[g] = emit_chunk & (rd_sel == 1'(g));

        s_chunk_packer #(.N(N), .LG(LG)) u_pack (
            .clk    (clk),
            .rst    (clr),
            .push   (push[g]),
            .base   (i_base),
            .last_in(i_base_last),
            .free   (free[g]),
            .data   (data[g]),
            .cnt    (cnt[g]),
            .sealed (sealed[g]),
            .last   (last[g])
        );
    end

    assign o_s_strobe   = (state == ST_EMIT);
    assign o_done       = done_q | (o_s_strobe & fin_now);
    assign o_base_ready = ~sealed[wr_sel] & ~last_seen & ~o_done;
    assign o_s          = emit_chunk ? data[rd_sel] : '0;
    assign o_s_valid    = emit_chunk ? cnt[rd_sel] : '0;

    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= ST_IDLE;
            wr_sel    <= 1'b0;
            rd_sel    <= 1'b0;
            last_seen <= 1'b0;
            eos_pend  <= 1'b0;
            marker    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            if (accept && i_base_last)
                last_seen <= 1'b1;
            if (seal_now)
                wr_sel <= ~wr_sel;
            case (state)
                ST_IDLE: begin
                    if (i_request_s) begin
                        if (eos_pend) begin
                            state    <= ST_EMIT;
                            marker   <= 1'b1;
                            eos_pend <= 1'b0;
                        end else if (avail) begin
                            state <= ST_EMIT;
                        end else begin
                            state <= ST_PEND;
                        end
                    end
                end
                ST_PEND: begin
                    if (seal_now)
                        state <= ST_EMIT;
                end
                ST_EMIT: begin
                    marker <= 1'b0;
                    if (!marker)
                        rd_sel <= ~rd_sel;
                    if (fin_now) begin
                        state  <= ST_END;
                        done_q <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                        // A full last chunk still owes an end-marker.
                        if (last[rd_sel])
                            eos_pend <= 1'b1;
                    end
                end
                ST_END:  state <= ST_END;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
